// File: rtl/acs_max_select_pkg.sv
// rtl/acs_max_select_pkg.sv - shared Viterbi types, defaults and saturating add
package acs_max_select_pkg;

  localparam int P_SIZE_DEF      = 32;
  localparam int POS_NUM_DEF     = 11;
  localparam int POS_NUM_BIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_EMIT  = 2'd2
  } acs_state_t;

  // Log-domain scores clamp at all-ones instead of wrapping.
  function automatic logic [P_SIZE_DEF-1:0] sat_add_fn(
    input logic [P_SIZE_DEF-1:0] a,
    input logic [P_SIZE_DEF-1:0] b
  );
    logic [P_SIZE_DEF:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[P_SIZE_DEF] ? '1 : full[P_SIZE_DEF-1:0];
  endfunction

endpackage

// File: rtl/acs_max_select_sat_add.sv
// rtl/acs_max_select_sat_add.sv - W-bit saturating unsigned adder
module sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum  = w_full[W] ? '1 : w_full[W-1:0];

endmodule

// File: rtl/acs_max_select.sv
// rtl/acs_max_select.sv - add-compare-select over all previous tags for one current tag
module acs_max_select
  import acs_max_select_pkg::*;
#(
  parameter int word_num     = 16,
  parameter int word_num_bit = 4,
  parameter int p_size       = P_SIZE_DEF,
  parameter int POS_num      = POS_NUM_DEF,
  parameter int POS_num_bit  = POS_NUM_BIT_DEF
) (
  input  logic                   clk,
  input  logic                   reset_acs_max_select,
  input  logic                   start_acs_max_select,
  input  logic                   stall_acs_max_select,
  input  logic [POS_num_bit-1:0] trans_idx_acs_max_select,
  input  logic [p_size-1:0]      prev_score_acs_max_select,
  input  logic [p_size-1:0]      trans_score_acs_max_select,
  input  logic [p_size-1:0]      emit_score_acs_max_select,
  output logic                   increment_enable_acs_max_select,
  output logic                   busy_acs_max_select,
  output logic [p_size-1:0]      best_score_acs_max_select,
  output logic [POS_num_bit-1:0] backptr_acs_max_select,
  output logic                   done_acs_max_select,
  output logic                   sync_err_acs_max_select
);

  localparam int unused_shared_params = word_num + word_num_bit;
  localparam logic [POS_num_bit-1:0] LAST_IDX = POS_num_bit'(POS_num - 1);

  acs_state_t             r_state;
  acs_state_t             w_state_nxt;
  logic [p_size-1:0]      r_acc;
  logic [POS_num_bit-1:0] r_argmax;
  logic [POS_num_bit-1:0] r_exp_idx;
  logic [p_size-1:0]      r_best;
  logic [POS_num_bit-1:0] r_backptr;
  logic                   r_done;
  logic                   r_sync_err;
  logic [p_size-1:0]      w_sum;
  logic [p_size-1:0]      w_emit_sum;
  logic                   w_term;

  sat_add #(.W(p_size)) u_trans_add (
    .i_a   (prev_score_acs_max_select),
    .i_b   (trans_score_acs_max_select),
    .o_sum (w_sum)
  );

  sat_add #(.W(p_size)) u_emit_add (
    .i_a   (r_acc),
    .i_b   (emit_score_acs_max_select),
    .o_sum (w_emit_sum)
  );

  // One term is consumed, and the counter advanced, on every unstalled sweep cycle.
  assign w_term = (r_state == ST_SWEEP) && !stall_acs_max_select;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_acs_max_select) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (w_term && (r_exp_idx == LAST_IDX)) w_state_nxt = ST_EMIT;
      ST_EMIT:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_acs_max_select) begin
    if (!reset_acs_max_select) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_argmax   <= '0;
      r_exp_idx  <= '0;
      r_best     <= '0;
      r_backptr  <= '0;
      r_done     <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_EMIT);
      case (r_state)
        ST_IDLE: begin
          if (start_acs_max_select) begin
            r_acc      <= '0;
            r_argmax   <= '0;
            r_exp_idx  <= '0;
            r_sync_err <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (w_term) begin
            // Strict compare keeps the lowest index on ties; first term always loads.
            if ((w_sum > r_acc) || (r_exp_idx == '0)) begin
              r_acc    <= w_sum;
              r_argmax <= trans_idx_acs_max_select;
            end
            r_exp_idx <= r_exp_idx + POS_num_bit'(1);
            if (trans_idx_acs_max_select != r_exp_idx) r_sync_err <= 1'b1;
          end
        end
        ST_EMIT: begin
          r_best    <= w_emit_sum;
          r_backptr <= r_argmax;
        end
        default: ;
      endcase
    end
  end

  assign increment_enable_acs_max_select = w_term;
  assign busy_acs_max_select             = (r_state != ST_IDLE);
  assign best_score_acs_max_select       = r_best;
  assign backptr_acs_max_select          = r_backptr;
  assign done_acs_max_select             = r_done;
  assign sync_err_acs_max_select         = r_sync_err;

endmodule

// File: tb/tb_acs_max_select.sv
// tb/tb_acs_max_select.sv - scoreboard bench for acs_max_select with a transition counter model
module tb_acs_max_select;

  typedef struct {
    logic [31:0] score;
    logic [3:0]  bptr;
    int          lat;
    int          start_cyc;
    int          inc_base;
    logic        serr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic [3:0]  trans_idx;
  logic [31:0] prev_in;
  logic [31:0] trans_in;
  logic [31:0] emit;
  logic        inc;
  logic        busy;
  logic [31:0] best;
  logic [3:0]  bptr;
  logic        done;
  logic        serr;

  logic [31:0] prev_mem [16];
  logic [31:0] trans_mem[16];
  logic        skew;
  logic [3:0]  cnt;
  int          cyc = 0;
  int          inc_total = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  acs_max_select dut (
    .clk                             (clk),
    .reset_acs_max_select            (rst_n),
    .start_acs_max_select            (start),
    .stall_acs_max_select            (stall),
    .trans_idx_acs_max_select        (trans_idx),
    .prev_score_acs_max_select       (prev_in),
    .trans_score_acs_max_select      (trans_in),
    .emit_score_acs_max_select       (emit),
    .increment_enable_acs_max_select (inc),
    .busy_acs_max_select             (busy),
    .best_score_acs_max_select       (best),
    .backptr_acs_max_select          (bptr),
    .done_acs_max_select             (done),
    .sync_err_acs_max_select         (serr)
  );

  // Transition counter model sharing the reset wire.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 4'd0;
    else if (inc) cnt <= (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (inc) inc_total <= inc_total + 1;
  end

  always_comb begin
    trans_idx = (skew && cnt == 4'd1) ? 4'd2 : cnt;
    prev_in   = prev_mem[trans_idx];
    trans_in  = trans_mem[trans_idx];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        mon_e = sb.pop_front();
        chk("best_score", best, mon_e.score);
        chk("backptr", 32'(bptr), 32'(mon_e.bptr));
        chk("latency", 32'(cyc - mon_e.start_cyc + 1), 32'(mon_e.lat));
        chk("increments", 32'(inc_total - mon_e.inc_base), 32'd11);
        chk("counter_wrap", 32'(cnt), 32'd0);
        chk("sync_err", 32'(serr), 32'(mon_e.serr));
      end
    end
  end

  task automatic load_vec(input int mode);
    for (int i = 0; i < 16; i++) begin
      prev_mem[i]  = 32'd0;
      trans_mem[i] = 32'd0;
    end
    for (int i = 0; i < 11; i++) begin
      case (mode)
        0: prev_mem[i] = 32'(100 + i);
        1: begin prev_mem[i] = 32'(50 - 2 * i); trans_mem[i] = 32'(2 * i); end
        2: begin prev_mem[i] = 32'(i); trans_mem[i] = (i == 6) ? 32'd1000 : 32'd0; end
        3: begin prev_mem[i] = (i == 3) ? 32'hFFFF_FFF0 : 32'd0; trans_mem[i] = (i == 3) ? 32'h20 : 32'd0; end
        default: prev_mem[i] = 32'(10 * i);
      endcase
    end
  endtask

  // Caller is positioned at a falling edge; start is sampled on the next rising edge.
  task automatic start_sweep(input logic [31:0] score, input logic [3:0] bp, input int lat, input logic se);
    exp_t e;
    e.score = score; e.bptr = bp; e.lat = lat; e.start_cyc = cyc + 1;
    e.inc_base = inc_total; e.serr = se;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cnt(input logic [3:0] v);
    int n = 0;
    while (!(cnt == v && busy === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(cnt == v && busy === 1'b1)) chk("cnt_timeout", 32'(cnt), 32'(v));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; skew = 1'b0; emit = 32'd0;
    load_vec(0);
    repeat (3) @(negedge clk);
    chk("rst_best", best, 32'd0);
    chk("rst_backptr", 32'(bptr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inc", 32'(inc), 32'd0);
    chk("rst_sync_err", 32'(serr), 32'd0);
    rst_n = 1'b1;

    // Basic sweep.
    @(negedge clk); emit = 32'd5;
    start_sweep(32'd115, 4'd10, 13, 1'b0);
    wait_done(40);

    // Ties, plus a start pulse mid-sweep that must be ignored.
    @(negedge clk); load_vec(1); emit = 32'd0;
    start_sweep(32'd50, 4'd0, 13, 1'b0);
    wait_cnt(4'd4);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(40);

    // Start in the same cycle as done is accepted.
    load_vec(2); emit = 32'd2;
    start_sweep(32'd1008, 4'd6, 13, 1'b0);
    wait_done(40);

    // Saturation.
    @(negedge clk); load_vec(3); emit = 32'd1;
    start_sweep(32'hFFFF_FFFF, 4'd3, 13, 1'b0);
    wait_done(40);

    // Three stall cycles mid-sweep.
    @(negedge clk); load_vec(0); emit = 32'd5;
    start_sweep(32'd115, 4'd10, 16, 1'b0);
    wait_cnt(4'd4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_inc", 32'(inc), 32'd0);
      @(negedge clk);
      chk("stall_cnt_hold", 32'(cnt), 32'd4);
    end
    stall = 1'b0;
    wait_done(40);

    // Index skew sets the sticky error.
    @(negedge clk); load_vec(4); emit = 32'd0; skew = 1'b1;
    start_sweep(32'd100, 4'd10, 13, 1'b1);
    wait_done(40);
    skew = 1'b0;

    // Next start clears the error.
    @(negedge clk); load_vec(2); emit = 32'd2;
    start_sweep(32'd1008, 4'd6, 13, 1'b0);
    chk("sync_err_cleared", 32'(serr), 32'd0);
    wait_done(40);

    // Reset mid-sweep at term 5, then a clean sweep.
    @(negedge clk); load_vec(0); emit = 32'd5;
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cnt(4'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_inc", 32'(inc), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_best", best, 32'd0);
    chk("midrst_backptr", 32'(bptr), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_sweep(32'd115, 4'd10, 13, 1'b0);
    wait_done(40);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
